// File: rtl/ex_stage_pkg.sv
// Shared opcode/result-class codes and bundle types for the execute stage.
// Build option: EX_FAST_MUL_EN selects the single-cycle multiplier.
package ex_stage_pkg;

  localparam int RegW    = 32;
  localparam int AluOpW  = 8;
  localparam int AluSelW = 3;

  typedef enum logic [AluOpW-1:0] {
    EXE_NOP_OP   = 8'b0000_0000,
    EXE_AND_OP   = 8'b0010_0100,
    EXE_OR_OP    = 8'b0010_0101,
    EXE_XOR_OP   = 8'b0010_0110,
    EXE_NOR_OP   = 8'b0010_0111,
    EXE_LUI_OP   = 8'b0101_1100,
    EXE_SLL_OP   = 8'b0111_1100,
    EXE_SLLV_OP  = 8'b0000_0100,
    EXE_SRL_OP   = 8'b0000_0010,
    EXE_SRLV_OP  = 8'b0000_0110,
    EXE_SRA_OP   = 8'b0000_0011,
    EXE_SRAV_OP  = 8'b0000_0111,
    EXE_MOV_OP   = 8'b0000_1010,
    EXE_MFHI_OP  = 8'b0001_0000,
    EXE_MTHI_OP  = 8'b0001_0001,
    EXE_MFLO_OP  = 8'b0001_0010,
    EXE_MTLO_OP  = 8'b0001_0011,
    EXE_MULT_OP  = 8'b0001_1000,
    EXE_MULTU_OP = 8'b0001_1001
  } aluop_e;

  typedef enum logic [AluSelW-1:0] {
    EXE_RES_NOP   = 3'b000,
    EXE_RES_LOGIC = 3'b001,
    EXE_RES_SHIFT = 3'b010,
    EXE_RES_MOVE  = 3'b011,
    EXE_RES_MUL   = 3'b101
  } alusel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [4:0]      wd;
    logic            wreg;
    logic [RegW-1:0] wdata;
    logic            whilo;
    logic [RegW-1:0] hi;
    logic [RegW-1:0] lo;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID <-> EX bundle: decoded op in, forwarding and stall back out.
// master = decode side, slave = execute side.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [AluOpW-1:0]  aluop_i;
  logic [AluSelW-1:0] alusel_i;
  logic [RegW-1:0]    reg1_i;
  logic [RegW-1:0]    reg2_i;
  logic [4:0]         wd_i;
  logic               wreg_i;
  logic [4:0]         ex_wd_o;
  logic               ex_wreg_o;
  logic [RegW-1:0]    ex_wdata_o;
  logic               stall_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  ex_wd_o, ex_wreg_o, ex_wdata_o, stall_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output ex_wd_o, ex_wreg_o, ex_wdata_o, stall_o
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, BITS multiplier bits per cycle.
// Signed ops run on magnitudes; the sign is re-applied on the product.
module ex_mul_iter
  import ex_stage_pkg::*;
#(
  parameter int BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] prod_o
);

  localparam int N  = 32 / BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_e    state_q, state_d;
  logic [63:0]   a_q, acc_q, part;
  logic [31:0]   b_q, abs_a, abs_b;
  logic [CW-1:0] cnt_q;
  logic          neg_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_IDLE: if (start_i) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == CW'(N - 1)) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == MUL_IDLE && start_i) || state_q == MUL_BUSY;
    done_o = state_q == MUL_DONE;
    prod_o = neg_q ? -acc_q : acc_q;
  end

  assign abs_a = (signed_i && a_i[31]) ? -a_i : a_i;
  assign abs_b = (signed_i && b_i[31]) ? -b_i : b_i;

  always_comb begin
    part = '0;
    for (int i = 0; i < BITS; i++)
      if (b_q[i]) part = part + (a_q << i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else if (state_q == MUL_IDLE && start_i) begin
      a_q   <= {32'h0, abs_a};
      b_q   <= abs_b;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= signed_i && (a_i[31] ^ b_i[31]);
    end else if (state_q == MUL_BUSY) begin
      acc_q <= acc_q + part;
      a_q   <= a_q << BITS;
      b_q   <= b_q >> BITS;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move results, HI/LO forwarding, MULT/MULTU.
// EX_FAST_MUL_EN: single-cycle multiply, never stalls.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_BITS_PER_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  ex_stage_if.slave       id,
  input  logic [RegW-1:0] hi_i,
  input  logic [RegW-1:0] lo_i,
  input  logic            mem_whilo_i,
  input  logic [RegW-1:0] mem_hi_i,
  input  logic [RegW-1:0] mem_lo_i,
  input  logic            wb_whilo_i,
  input  logic [RegW-1:0] wb_hi_i,
  input  logic [RegW-1:0] wb_lo_i,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [RegW-1:0] wdata_o,
  output logic            whilo_o,
  output logic [RegW-1:0] hi_o,
  output logic [RegW-1:0] lo_o
);

  logic [RegW-1:0] logic_res, shift_res, move_res, hi_f, lo_f;
  logic [4:0]      sh_amt;
  logic [63:0]     prod;
  logic            is_mul, mul_signed, mul_done, stall;
  ex_mem_t         res, exm_d, exm_q;

  assign is_mul = id.alusel_i == EXE_RES_MUL &&
                  (id.aluop_i == EXE_MULT_OP ||
                   id.aluop_i == EXE_MULTU_OP);
  assign mul_signed = id.aluop_i == EXE_MULT_OP;

`ifdef EX_FAST_MUL_EN
  logic [63:0] ma, mb;
  assign ma       = {{32{mul_signed & id.reg1_i[31]}}, id.reg1_i};
  assign mb       = {{32{mul_signed & id.reg2_i[31]}}, id.reg2_i};
  assign prod     = ma * mb;
  assign mul_done = 1'b1;
  assign stall    = 1'b0;
`else
  logic mul_busy;
  ex_mul_iter #(.BITS(MUL_BITS_PER_CYC)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_mul),
    .signed_i (mul_signed),
    .a_i      (id.reg1_i),
    .b_i      (id.reg2_i),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .prod_o   (prod)
  );
  assign stall = mul_busy & ~rst;
`endif

  always_comb begin
    logic_res = '0;
    case (id.aluop_i)
      EXE_OR_OP:  logic_res = id.reg1_i | id.reg2_i;
      EXE_AND_OP: logic_res = id.reg1_i & id.reg2_i;
      EXE_XOR_OP: logic_res = id.reg1_i ^ id.reg2_i;
      EXE_NOR_OP: logic_res = ~(id.reg1_i | id.reg2_i);
      EXE_LUI_OP: logic_res = {id.reg1_i[15:0], 16'h0};
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    sh_amt    = id.reg1_i[10:6];
    unique case (1'b1)
      id.aluop_i == EXE_SLLV_OP,
      id.aluop_i == EXE_SRLV_OP,
      id.aluop_i == EXE_SRAV_OP: sh_amt = id.reg1_i[4:0];
      default:                   sh_amt = id.reg1_i[10:6];
    endcase
    case (id.aluop_i)
      EXE_SLL_OP, EXE_SLLV_OP: shift_res = id.reg2_i << sh_amt;
      EXE_SRL_OP, EXE_SRLV_OP: shift_res = id.reg2_i >> sh_amt;
      EXE_SRA_OP, EXE_SRAV_OP:
        shift_res = $unsigned($signed(id.reg2_i) >>> sh_amt);
      default: shift_res = '0;
    endcase
  end

  // Youngest pending HI/LO write wins.
  always_comb begin
    hi_f = hi_i;
    lo_f = lo_i;
    if (mem_whilo_i) begin
      hi_f = mem_hi_i;
      lo_f = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_f = wb_hi_i;
      lo_f = wb_lo_i;
    end
  end

  always_comb begin
    move_res = '0;
    case (id.aluop_i)
      EXE_MFHI_OP: move_res = hi_f;
      EXE_MFLO_OP: move_res = lo_f;
      EXE_MOV_OP:  move_res = id.reg1_i;
      default:     move_res = '0;
    endcase
  end

  always_comb begin
    res      = '0;
    res.wd   = id.wd_i;
    res.wreg = id.wreg_i;
    case (id.alusel_i)
      EXE_RES_LOGIC: res.wdata = logic_res;
      EXE_RES_SHIFT: res.wdata = shift_res;
      EXE_RES_MOVE: begin
        res.wdata = move_res;
        if (id.aluop_i == EXE_MTHI_OP) begin
          res.whilo = 1'b1;
          res.hi    = id.reg1_i;
          res.lo    = lo_f;
        end else if (id.aluop_i == EXE_MTLO_OP) begin
          res.whilo = 1'b1;
          res.hi    = hi_f;
          res.lo    = id.reg1_i;
        end
      end
      EXE_RES_MUL: begin
        res.wreg = 1'b0;
        if (is_mul && mul_done) begin
          res.whilo = 1'b1;
          res.hi    = prod[63:32];
          res.lo    = prod[31:0];
        end
      end
      default: res.wdata = '0;
    endcase
  end

  assign id.ex_wd_o    = res.wd;
  assign id.ex_wreg_o  = res.wreg & ~stall;
  assign id.ex_wdata_o = res.wdata;
  assign id.stall_o    = stall;

  assign exm_d = stall ? '0 : res;

  always_ff @(posedge clk) begin
    if (rst) exm_q <= '0;
    else     exm_q <= exm_d;
  end

  assign wd_o    = exm_q.wd;
  assign wreg_o  = exm_q.wreg;
  assign wdata_o = exm_q.wdata;
  assign whilo_o = exm_q.whilo;
  assign hi_o    = exm_q.hi;
  assign lo_o    = exm_q.lo;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed table, multiply/reset sequences,
// and random ops against a spec-level reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef EX_FAST_MUL_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 32 / 2 + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus();

  logic [31:0] hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic        mem_whilo_i, wb_whilo_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int nvec = 0;
  int nerr = 0;

  ex_stage u_dut (
    .clk         (clk),
    .rst         (rst),
    .id          (bus),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .mem_whilo_i (mem_whilo_i),
    .mem_hi_i    (mem_hi_i),
    .mem_lo_i    (mem_lo_i),
    .wb_whilo_i  (wb_whilo_i),
    .wb_hi_i     (wb_hi_i),
    .wb_lo_i     (wb_lo_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1, r2;
    logic        mw;
    logic [31:0] mh, ml;
    logic        ww;
    logic [31:0] wh, wl, h, l;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  typedef struct packed {
    logic [7:0] op;
    logic [2:0] sel;
  } opsel_t;

  vec_t   tbl[$];
  opsel_t ops[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wreg);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
  endtask

  task automatic set_hilo(input logic mw, input logic [31:0] mh,
                          input logic [31:0] ml, input logic ww,
                          input logic [31:0] wh, input logic [31:0] wl,
                          input logic [31:0] h, input logic [31:0] l);
    mem_whilo_i = mw; mem_hi_i = mh; mem_lo_i = ml;
    wb_whilo_i  = ww; wb_hi_i  = wh; wb_lo_i  = wl;
    hi_i = h; lo_i = l;
  endtask

  function automatic vec_t mk(
      input logic [7:0] op, input logic [2:0] sel,
      input logic [31:0] r1, input logic [31:0] r2,
      input logic mw, input logic [31:0] mh, input logic [31:0] ml,
      input logic ww, input logic [31:0] wh, input logic [31:0] wl,
      input logic [31:0] h, input logic [31:0] l,
      input logic [31:0] ewd, input logic ewh,
      input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2;
    v.mw = mw; v.mh = mh; v.ml = ml;
    v.ww = ww; v.wh = wh; v.wl = wl; v.h = h; v.l = l;
    v.e_wdata = ewd; v.e_whilo = ewh; v.e_hi = eh; v.e_lo = el;
    return v;
  endfunction

  // Spec-level model of one single-cycle op.
  function automatic void model(input logic [7:0] op,
      input logic [2:0] sel, input logic [31:0] r1,
      input logic [31:0] r2, output logic [31:0] wdata,
      output logic wh, output logic [31:0] oh, output logic [31:0] ol);
    logic [31:0] hf, lf, ones;
    int amt;
    ones = 32'hFFFF_FFFF;
    hf = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    lf = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
    wdata = 0; wh = 0; oh = 0; ol = 0;
    if (op == EXE_SLLV_OP || op == EXE_SRLV_OP || op == EXE_SRAV_OP)
      amt = int'(r1 % 32);
    else
      amt = int'((r1 / 64) % 32);
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_OR_OP)  wdata = r1 | r2;
      if (op == EXE_AND_OP) wdata = r1 & r2;
      if (op == EXE_XOR_OP) wdata = r1 ^ r2;
      if (op == EXE_NOR_OP) wdata = ~(r1 | r2);
      if (op == EXE_LUI_OP) wdata = (r1 % 65536) * 65536;
    end else if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_SLL_OP || op == EXE_SLLV_OP) wdata = r2 << amt;
      if (op == EXE_SRL_OP || op == EXE_SRLV_OP) wdata = r2 >> amt;
      if (op == EXE_SRA_OP || op == EXE_SRAV_OP)
        wdata = (r2 >> amt) | (r2[31] ? ~(ones >> amt) : 32'h0);
    end else if (sel == EXE_RES_MOVE) begin
      if (op == EXE_MFHI_OP) wdata = hf;
      if (op == EXE_MFLO_OP) wdata = lf;
      if (op == EXE_MOV_OP)  wdata = r1;
      if (op == EXE_MTHI_OP) begin wh = 1; oh = r1; ol = lf; end
      if (op == EXE_MTLO_OP) begin wh = 1; oh = hf; ol = r1; end
    end
  endfunction

  function automatic logic [63:0] mul_ref(input logic [7:0] op,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (op == EXE_MULT_OP) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic run_mul(input string nm, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    drive(op, EXE_RES_MUL, a, b, 5'd3, 1'b0);
    #1;
    while (bus.stall_o && n < 100) begin
      n++;
      if (n == 3)
        chk({nm, ".bubble"}, 128'({wreg_o, whilo_o, bus.ex_wreg_o}),
            128'(0));
      @(negedge clk);
      #1;
    end
    chk({nm, ".stall_cycles"}, 128'(n), 128'(EXP_STALL));
    chk({nm, ".done_fwd_wreg"}, 128'(bus.ex_wreg_o), 128'(0));
    @(posedge clk);
    #1;
    chk({nm, ".hilo"}, 128'({whilo_o, wreg_o, hi_o, lo_o}),
        128'({1'b1, 1'b0, exp}));
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    chk({nm, ".no_retrigger"}, 128'(bus.stall_o), 128'(0));
    @(posedge clk);
    #1;
    chk({nm, ".after_whilo"}, 128'({whilo_o, bus.stall_o}), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ewd, eh, el, r1, r2;
    logic        ewh, wreg;
    logic [4:0]  wd;
    opsel_t      os;

    rst = 1'b1;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    set_hilo(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.outs", 128'({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o}),
        128'(0));
    chk("reset.stall", 128'(bus.stall_o), 128'(0));
    rst = 1'b0;

    tbl.push_back(mk(EXE_OR_OP, EXE_RES_LOGIC, 32'h1100, 32'h20,
      0,0,0, 0,0,0, 0,0, 32'h0000_1120, 0, 0, 0));
    tbl.push_back(mk(EXE_SRA_OP, EXE_RES_SHIFT, 32'h100, 32'h8000_0000,
      0,0,0, 0,0,0, 0,0, 32'hF800_0000, 0, 0, 0));
    tbl.push_back(mk(EXE_SRLV_OP, EXE_RES_SHIFT, 32'h4, 32'h8000_0000,
      0,0,0, 0,0,0, 0,0, 32'h0800_0000, 0, 0, 0));
    tbl.push_back(mk(EXE_MFHI_OP, EXE_RES_MOVE, 0, 0,
      1, 32'hAAAA_0000, 0, 1, 32'h5555, 0, 32'h1, 0,
      32'hAAAA_0000, 0, 0, 0));
    tbl.push_back(mk(EXE_MFLO_OP, EXE_RES_MOVE, 0, 0,
      0, 0, 32'h77, 1, 0, 32'h1234, 0, 32'h9999,
      32'h1234, 0, 0, 0));
    tbl.push_back(mk(EXE_MFHI_OP, EXE_RES_MOVE, 0, 0,
      0,0,0, 0,0,0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 0));
    tbl.push_back(mk(EXE_MTHI_OP, EXE_RES_MOVE, 32'h1111_2222, 0,
      0,0,0, 0,0,0, 32'h9, 32'h33, 0, 1, 32'h1111_2222, 32'h33));
    tbl.push_back(mk(EXE_MTLO_OP, EXE_RES_MOVE, 32'h77, 0,
      1, 32'h55, 32'h66, 0,0,0, 32'h44, 0, 0, 1, 32'h55, 32'h77));
    tbl.push_back(mk(EXE_LUI_OP, EXE_RES_LOGIC, 32'h0000_ABCD, 0,
      0,0,0, 0,0,0, 0,0, 32'hABCD_0000, 0, 0, 0));
    tbl.push_back(mk(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0,
      32'h0F0F_0000, 0,0,0, 0,0,0, 0,0, 32'h0000_0F0F, 0, 0, 0));
    tbl.push_back(mk(EXE_SLL_OP, EXE_RES_SHIFT, 32'h7C0, 32'h3,
      0,0,0, 0,0,0, 0,0, 32'h8000_0000, 0, 0, 0));
    tbl.push_back(mk(EXE_OR_OP, 3'b111, 32'h1, 32'h2,
      0,0,0, 0,0,0, 0,0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF00_FF00,
      32'h0FF0_0FF0, 0,0,0, 0,0,0, 0,0, 32'hF0F0_F0F0, 0, 0, 0));
    tbl.push_back(mk(EXE_SRAV_OP, EXE_RES_SHIFT, 32'h24, 32'h4000_0000,
      0,0,0, 0,0,0, 0,0, 32'h0400_0000, 0, 0, 0));
    tbl.push_back(mk(EXE_MOV_OP, EXE_RES_MOVE, 32'hCAFE_F00D, 0,
      0,0,0, 0,0,0, 0,0, 32'hCAFE_F00D, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      set_hilo(tbl[i].mw, tbl[i].mh, tbl[i].ml, tbl[i].ww,
               tbl[i].wh, tbl[i].wl, tbl[i].h, tbl[i].l);
      drive(tbl[i].op, tbl[i].sel, tbl[i].r1, tbl[i].r2, 5'(i), 1'b1);
      #1;
      chk($sformatf("tbl%0d.fwd", i),
          128'({bus.ex_wdata_o, bus.ex_wreg_o, bus.ex_wd_o, bus.stall_o}),
          128'({tbl[i].e_wdata, 1'b1, 5'(i), 1'b0}));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.reg", i),
          128'({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o}),
          128'({5'(i), 1'b1, tbl[i].e_wdata, tbl[i].e_whilo,
                tbl[i].e_hi, tbl[i].e_lo}));
    end

    set_hilo(0, 0, 0, 0, 0, 0, 0, 0);
    run_mul("mult_neg", EXE_MULT_OP, 32'hFFFF_FFFF, 32'h2,
            64'hFFFF_FFFF_FFFF_FFFE);
    run_mul("multu", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'h2,
            64'h0000_0001_FFFF_FFFE);

    // Reset lands while the multiplier is at BUSY step 5.
    @(negedge clk);
    drive(EXE_MULT_OP, EXE_RES_MUL, 32'h5, 32'h7, 5'd0, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("abort.outs", 128'({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o}),
        128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.stall", 128'(bus.stall_o), 128'(0));
    @(posedge clk);
    #1;
    chk("abort.no_whilo", 128'(whilo_o), 128'(0));
    run_mul("mult_after_abort", EXE_MULT_OP, 32'hFFFF_FFFD, 32'h7,
            64'hFFFF_FFFF_FFFF_FFEB);

    ops.push_back({EXE_OR_OP,   EXE_RES_LOGIC});
    ops.push_back({EXE_AND_OP,  EXE_RES_LOGIC});
    ops.push_back({EXE_XOR_OP,  EXE_RES_LOGIC});
    ops.push_back({EXE_NOR_OP,  EXE_RES_LOGIC});
    ops.push_back({EXE_LUI_OP,  EXE_RES_LOGIC});
    ops.push_back({EXE_SLL_OP,  EXE_RES_SHIFT});
    ops.push_back({EXE_SRL_OP,  EXE_RES_SHIFT});
    ops.push_back({EXE_SRA_OP,  EXE_RES_SHIFT});
    ops.push_back({EXE_SLLV_OP, EXE_RES_SHIFT});
    ops.push_back({EXE_SRLV_OP, EXE_RES_SHIFT});
    ops.push_back({EXE_SRAV_OP, EXE_RES_SHIFT});
    ops.push_back({EXE_MOV_OP,  EXE_RES_MOVE});
    ops.push_back({EXE_MFHI_OP, EXE_RES_MOVE});
    ops.push_back({EXE_MFLO_OP, EXE_RES_MOVE});
    ops.push_back({EXE_MTHI_OP, EXE_RES_MOVE});
    ops.push_back({EXE_MTLO_OP, EXE_RES_MOVE});
    ops.push_back({EXE_NOP_OP,  EXE_RES_NOP});

    for (int k = 0; k < 200; k++) begin
      os   = ops[$urandom_range(ops.size() - 1)];
      r1   = $urandom;
      r2   = $urandom;
      wd   = 5'($urandom_range(31));
      wreg = 1'($urandom_range(1));
      @(negedge clk);
      set_hilo(1'($urandom_range(1)), $urandom, $urandom,
               1'($urandom_range(1)), $urandom, $urandom,
               $urandom, $urandom);
      drive(os.op, os.sel, r1, r2, wd, wreg);
      model(os.op, os.sel, r1, r2, ewd, ewh, eh, el);
      #1;
      chk($sformatf("rnd%0d.fwd", k),
          128'({bus.ex_wdata_o, bus.ex_wreg_o, bus.ex_wd_o, bus.stall_o}),
          128'({ewd, wreg, wd, 1'b0}));
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d.reg", k),
          128'({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o}),
          128'({wd, wreg, ewd, ewh, eh, el}));
      if (k % 20 == 0) begin
        r1 = $urandom;
        r2 = $urandom;
        os.op = (k % 40 == 0) ? EXE_MULT_OP : EXE_MULTU_OP;
        run_mul($sformatf("rmul%0d", k), os.op, r1, r2,
                mul_ref(os.op, r1, r2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
